instruction_cache: RTL



---
 rtl/mips_cache_pkg.sv | 24 ++
 rtl/icache_line_store.sv | 64 ++++++
 rtl/instruction_cache.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mips_cache_pkg.sv
// Shared types and address-field widths for the MIPS instruction cache.
// The derived widths describe the default geometry; parameterised users recompute them.
package mips_cache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_W     = $clog2(WORD_BYTES);

    localparam int unsigned OFFSET_W = 2;
    localparam int unsigned INDEX_W  = 6;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W - BYTE_W;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } cache_state_e;

    // Tag width left over once byte, offset and index bits are removed.
    function automatic int unsigned tag_width(input int unsigned lines, input int unsigned words);
        return ADDR_W - $clog2(lines) - $clog2(words) - BYTE_W;
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Reads are combinational; writes, tag updates and valid changes happen on posedge.
module icache_line_store
    import mips_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES       = 2 ** INDEX_W,
    parameter int unsigned WORDS_PER_BLOCK = 2 ** OFFSET_W,
    parameter int unsigned TAG_BITS        = TAG_W
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [$clog2(NUM_LINES)-1:0]       rd_index,
    input  logic [$clog2(WORDS_PER_BLOCK)-1:0] rd_offset,
    input  logic                               wr_en,
    input  logic [$clog2(NUM_LINES)-1:0]       wr_index,
    input  logic [$clog2(WORDS_PER_BLOCK)-1:0] wr_offset,
    input  logic [WORD_W-1:0]                  wr_data,
    input  logic                               set_valid,
    input  logic [TAG_BITS-1:0]                set_tag,
    input  logic                               inval_all,
    output logic                               rd_valid,
    output logic [TAG_BITS-1:0]                rd_tag,
    output logic [WORD_W-1:0]                  rd_word
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [WORD_W-1:0]    data_q [NUM_LINES][WORDS_PER_BLOCK];

    // Invalidate-all first so a line completing in the same cycle still ends valid.
    always_comb begin
        valid_d = valid_q;
        if (inval_all) begin
            valid_d = '0;
        end
        if (set_valid) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clock) begin
        if (set_valid) begin
            tag_q[wr_index] <= set_tag;
        end
        if (wr_en) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_word  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with word-by-word block refill.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_COUNTERS_EN.
module instruction_cache
    import mips_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES       = 2 ** INDEX_W,
    parameter int unsigned WORDS_PER_BLOCK = 2 ** OFFSET_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] instruction_address,
    input  logic              flush,
    output logic [WORD_W-1:0] instruction,
    output logic              hit,
    output logic              mem_read_request,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [WORD_W-1:0] mem_read_data,
    input  logic              mem_data_valid
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int unsigned OFF_W    = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned IDX_W    = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS = tag_width(NUM_LINES, WORDS_PER_BLOCK);
    localparam int unsigned IDX_LSB  = BYTE_W + OFF_W;
    localparam int unsigned TAG_LSB  = IDX_LSB + IDX_W;

    logic [OFF_W-1:0]    rd_offset;
    logic [IDX_W-1:0]    rd_index;
    logic [TAG_BITS-1:0] rd_tag;
    logic                unused_byte_bits;

    assign rd_offset        = instruction_address[IDX_LSB-1:BYTE_W];
    assign rd_index         = instruction_address[TAG_LSB-1:IDX_LSB];
    assign rd_tag           = instruction_address[ADDR_W-1:TAG_LSB];
    assign unused_byte_bits = ^instruction_address[BYTE_W-1:0];

    cache_state_e        state_q;
    cache_state_e        state_d;
    logic [OFF_W-1:0]    cnt_q;
    logic [OFF_W-1:0]    cnt_d;
    logic [IDX_W-1:0]    ref_idx_q;
    logic [IDX_W-1:0]    ref_idx_d;
    logic [TAG_BITS-1:0] ref_tag_q;
    logic [TAG_BITS-1:0] ref_tag_d;

    logic                line_valid;
    logic [TAG_BITS-1:0] line_tag;
    logic [WORD_W-1:0]   line_word;
    logic                lookup_hit;
    logic                wr_en;
    logic                set_valid;

    icache_line_store #(
        .NUM_LINES       (NUM_LINES),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .TAG_BITS        (TAG_BITS)
    ) u_store (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_index  (rd_index),
        .rd_offset (rd_offset),
        .wr_en     (wr_en),
        .wr_index  (ref_idx_q),
        .wr_offset (cnt_q),
        .wr_data   (mem_read_data),
        .set_valid (set_valid),
        .set_tag   (ref_tag_q),
        .inval_all (flush),
        .rd_valid  (line_valid),
        .rd_tag    (line_tag),
        .rd_word   (line_word)
    );

    // Lookup, miss detection and refill sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ref_idx_d  = ref_idx_q;
        ref_tag_d  = ref_tag_q;
        lookup_hit = 1'b0;
        wr_en      = 1'b0;
        set_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                lookup_hit = !flush && line_valid && (line_tag == rd_tag);
                if (!flush && !lookup_hit) begin
                    state_d   = REFILL;
                    cnt_d     = '0;
                    ref_idx_d = rd_index;
                    ref_tag_d = rd_tag;
                end
            end
            REFILL: begin
                if (mem_data_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + OFF_W'(1);
                    if (cnt_q == OFF_W'(WORDS_PER_BLOCK - 1)) begin
                        set_valid = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ref_idx_q <= '0;
            ref_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_idx_q <= ref_idx_d;
            ref_tag_q <= ref_tag_d;
        end
    end

    assign hit              = lookup_hit;
    assign instruction      = lookup_hit ? line_word : '0;
    assign mem_read_request = (state_q == REFILL);
    // Block base plus word counter; parked at zero outside a refill.
    assign mem_address      = (state_q == REFILL) ? {ref_tag_q, ref_idx_q, cnt_q, {BYTE_W{1'b0}}}
                                                  : '0;

`ifdef ICACHE_PERF_COUNTERS_EN
    logic        miss_start;
    logic [31:0] hit_cnt_q;
    logic [31:0] hit_cnt_d;
    logic [31:0] miss_cnt_q;
    logic [31:0] miss_cnt_d;

    assign miss_start = (state_q == IDLE) && (state_d == REFILL);

    always_comb begin
        hit_cnt_d  = hit_cnt_q + 32'(lookup_hit);
        miss_cnt_d = miss_cnt_q + 32'(miss_start);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
